// File: rtl/awg_dma_pkg.sv
// Shared constants and encodings for the AWG DMA read-channel arbiter.
package awg_dma_pkg;

  localparam int ADDR_W = 33;
  localparam int DATA_W = 128;

  // Requester IDs double as bit positions in the one-hot grant.
  localparam logic REQ_IC = 1'b0;
  localparam logic REQ_WF = 1'b1;

  localparam logic [1:0] GRANT_NONE = 2'b00;
  localparam logic [1:0] GRANT_IC   = 2'b01;
  localparam logic [1:0] GRANT_WF   = 2'b10;

  typedef enum logic [1:0] {
    ARB   = 2'd0,
    OWN   = 2'd1,
    DRAIN = 2'd2
  } arb_state_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin pick: a sole requester wins, a tie goes to the one that did not own last.
module rr_arb2
  import awg_dma_pkg::*;
(
  input  logic [1:0] valid_i,
  input  logic       rr_last_i,
  output logic       any_o,
  output logic       winner_o
);

  assign any_o    = |valid_i;
  assign winner_o = (&valid_i) ? ~rr_last_i : valid_i[REQ_WF];

endmodule

// File: rtl/dma_rd_arb.sv
// Shares the DDR DMA read channel between the icache fill engine (IC) and the
// waveform fetch engine (WF) with round-robin arbitration and burst locking.
module dma_rd_arb
  import awg_dma_pkg::*;
#(
  parameter int MAX_BURST = 512,
  parameter int GAP_MAX   = 4,
  parameter int CNT_W     = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              ic_rd_valid,
  input  logic [ADDR_W-1:0] ic_rd_addr,
  output logic              ic_rd_ack,
  input  logic              wf_rd_valid,
  input  logic [ADDR_W-1:0] wf_rd_addr,
  output logic              wf_rd_ack,
  output logic [DATA_W-1:0] rd_data,
  output logic              dma_rd_valid,
  output logic [ADDR_W-1:0] dma_rd_addr,
  input  logic              dma_rd_ack,
  input  logic [DATA_W-1:0] dma_rd_data,
  output logic [1:0]        grant,
  output logic              busy
);

  localparam logic [CNT_W-1:0] BEAT_LAST = CNT_W'(MAX_BURST - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_MAX - 1);

  arb_state_e       state_q;
  logic [1:0]       grant_q;
  logic [CNT_W-1:0] beat_cnt_q;
  logic [CNT_W-1:0] gap_cnt_q;
  logic             rr_last_q;

  logic             req_any;
  logic             winner;
  logic             owner;
  logic             owner_valid;
  logic             active;
  logic             exit_arb;
  logic             exit_drain;

  rr_arb2 u_rr_arb2 (
    .valid_i   ({wf_rd_valid, ic_rd_valid}),
    .rr_last_i (rr_last_q),
    .any_o     (req_any),
    .winner_o  (winner)
  );

  assign active      = (state_q != ARB);
  assign owner       = grant_q[REQ_WF];
  assign owner_valid = owner ? wf_rd_valid : ic_rd_valid;

  // Channel mux is combinational so a granted beat reaches DMA CTRL without extra latency.
  assign dma_rd_valid = active & owner_valid;
  assign dma_rd_addr  = active ? (owner ? wf_rd_addr : ic_rd_addr) : '0;
  assign ic_rd_ack    = active & ~owner & dma_rd_ack;
  assign wf_rd_ack    = active &  owner & dma_rd_ack;
  assign rd_data      = dma_rd_data;
  assign grant        = grant_q;
  assign busy         = active;

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    exit_arb   = 1'b0;
    exit_drain = 1'b0;
    case (state_q)
      OWN: begin
        if (dma_rd_ack && (beat_cnt_q == BEAT_LAST)) begin
          exit_arb = 1'b1;
        end else if (flush) begin
          // A beat already presented to DMA CTRL must complete before release.
          if (owner_valid && !dma_rd_ack) exit_drain = 1'b1;
          else                            exit_arb   = 1'b1;
        end else if (!owner_valid && (gap_cnt_q == GAP_LAST)) begin
          exit_arb = 1'b1;
        end
      end
      DRAIN:   exit_arb = dma_rd_ack;
      default: ;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ARB;
      grant_q    <= GRANT_NONE;
      beat_cnt_q <= '0;
      gap_cnt_q  <= '0;
      rr_last_q  <= REQ_WF;
    end else begin
      case (state_q)
        ARB: begin
          if (req_any) begin
            grant_q <= winner ? GRANT_WF : GRANT_IC;
            state_q <= OWN;
          end
        end
        OWN, DRAIN: begin
          if (exit_arb) begin
            state_q    <= ARB;
            grant_q    <= GRANT_NONE;
            rr_last_q  <= owner;
            beat_cnt_q <= '0;
            gap_cnt_q  <= '0;
          end else if (exit_drain) begin
            state_q <= DRAIN;
          end else if (state_q == OWN) begin
            if (dma_rd_ack) beat_cnt_q <= beat_cnt_q + 1'b1;
            if (owner_valid)                 gap_cnt_q <= '0;
            else if (gap_cnt_q != GAP_LAST)  gap_cnt_q <= gap_cnt_q + 1'b1;
          end
        end
        default: state_q <= ARB;
      endcase
    end
  end

endmodule

// File: tb/tb_dma_rd_arb.sv
// Directed self-checking bench for dma_rd_arb.
module tb_dma_rd_arb;
  import awg_dma_pkg::*;

  logic              clk = 1'b0;
  logic              rst;
  logic              flush;
  logic              ic_v, wf_v;
  logic [ADDR_W-1:0] ic_a, wf_a;
  logic              ic_rd_ack, wf_rd_ack;
  logic [DATA_W-1:0] rd_data;
  logic              dma_rd_valid;
  logic [ADDR_W-1:0] dma_rd_addr;
  logic              dma_ack;
  logic [DATA_W-1:0] dma_data;
  logic [1:0]        grant;
  logic              busy;

  int checks = 0;
  int errors = 0;
  int ic_ack_cnt, wf_ack_cnt;
  logic [1:0] y_grant, z_grant;

  localparam logic [ADDR_W-1:0] IC_A0 = 33'h0_0000_1000;
  localparam logic [ADDR_W-1:0] IC_A1 = 33'h0_0000_1040;
  localparam logic [ADDR_W-1:0] WF_A0 = 33'h0_0000_2000;
  localparam logic [ADDR_W-1:0] WF_HI = 33'h1_0000_0040;
  localparam logic [DATA_W-1:0] DATA0 = 128'h0123_4567_89ab_cdef_fedc_ba98_7654_3210;

  dma_rd_arb u_dut (
    .clk          (clk),
    .rst          (rst),
    .flush        (flush),
    .ic_rd_valid  (ic_v),
    .ic_rd_addr   (ic_a),
    .ic_rd_ack    (ic_rd_ack),
    .wf_rd_valid  (wf_v),
    .wf_rd_addr   (wf_a),
    .wf_rd_ack    (wf_rd_ack),
    .rd_data      (rd_data),
    .dma_rd_valid (dma_rd_valid),
    .dma_rd_addr  (dma_rd_addr),
    .dma_rd_ack   (dma_ack),
    .dma_rd_data  (dma_data),
    .grant        (grant),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1; flush = 1'b0; ic_v = 1'b0; wf_v = 1'b0;
    ic_a = '0; wf_a = '0; dma_ack = 1'b0; dma_data = '0;
    tick(); tick();
    rst = 1'b0;
  endtask

  // One IC beat, engine style: valid, valid+ack, one idle cycle.
  task automatic ic_beat(input logic [ADDR_W-1:0] a);
    ic_v = 1'b1; ic_a = a; dma_ack = 1'b0;
    mid(); tick();
    dma_ack = 1'b1; dma_data = {4{a[31:0]}};
    mid();
    ic_ack_cnt += int'(ic_rd_ack);
    wf_ack_cnt += int'(wf_rd_ack);
    y_grant = grant;
    tick();
    ic_v = 1'b0; dma_ack = 1'b0;
    mid();
    z_grant = grant;
    tick();
  endtask

  initial begin
    // Reset values and single IC request.
    do_reset();
    mid();
    check("rst_grant", grant, 2'b00);
    check("rst_busy", busy, 1'b0);
    check("rst_dma_valid", dma_rd_valid, 1'b0);
    check("rst_dma_addr", dma_rd_addr, '0);
    check("rst_acks", {ic_rd_ack, wf_rd_ack}, 2'b00);
    tick();
    ic_v = 1'b1; ic_a = IC_A0;
    mid();
    check("t1_arb_no_valid", dma_rd_valid, 1'b0);
    tick();
    mid();
    check("t1_grant_ic", grant, 2'b01);
    check("t1_busy", busy, 1'b1);
    check("t1_dma_valid", dma_rd_valid, 1'b1);
    check("t1_dma_addr", dma_rd_addr, 33'h1000);
    check("t1_no_early_ack", ic_rd_ack, 1'b0);
    tick(); tick();
    dma_ack = 1'b1; dma_data = DATA0;
    mid();
    check("t1_ic_ack", ic_rd_ack, 1'b1);
    check("t1_wf_ack", wf_rd_ack, 1'b0);
    check("t1_rd_data", rd_data, DATA0);
    tick();
    ic_v = 1'b0; dma_ack = 1'b0;
    tick(); tick(); tick();
    mid();
    check("t1_gap4_still_owned", grant, 2'b01);
    tick();
    mid();
    check("t1_gap_release", grant, 2'b00);
    check("t1_gap_release_busy", busy, 1'b0);

    // Full 512-beat IC burst with WF waiting.
    do_reset();
    ic_v = 1'b1; ic_a = IC_A0; wf_v = 1'b1; wf_a = WF_A0;
    tick();
    ic_ack_cnt = 0; wf_ack_cnt = 0;
    for (int b = 0; b < 512; b++) ic_beat(IC_A0 + ADDR_W'(b * 16));
    check("t2_ic_acks", ic_ack_cnt, 512);
    check("t2_wf_acks", wf_ack_cnt, 0);
    check("t2_last_ack_grant", y_grant, 2'b01);
    check("t2_after_last_grant", z_grant, 2'b00);
    mid();
    check("t2_wf_granted", grant, 2'b10);
    check("t2_wf_addr", dma_rd_addr, WF_A0);
    tick();
    dma_ack = 1'b1;
    mid();
    check("t2_wf_ack", {ic_rd_ack, wf_rd_ack}, 2'b01);

    // Gap release with WF waiting, then a tie goes back to IC.
    do_reset();
    ic_v = 1'b1; ic_a = IC_A0;
    tick();
    wf_v = 1'b1; wf_a = WF_A0; dma_ack = 1'b1;
    mid();
    check("t3_ic_ack", ic_rd_ack, 1'b1);
    tick();
    ic_v = 1'b0; dma_ack = 1'b0;
    tick(); tick(); tick();
    mid();
    check("t3_4th_idle_owned", grant, 2'b01);
    tick();
    mid();
    check("t3_released", grant, 2'b00);
    tick();
    ic_v = 1'b1; ic_a = IC_A1; dma_ack = 1'b1;
    mid();
    check("t3_wf_granted", grant, 2'b10);
    check("t3_wf_ack", {ic_rd_ack, wf_rd_ack}, 2'b01);
    tick();
    wf_v = 1'b0; dma_ack = 1'b0;
    tick(); tick(); tick(); tick();
    wf_v = 1'b1;
    mid();
    check("t3_tie_in_arb", grant, 2'b00);
    tick();
    mid();
    check("t3_tie_to_ic", grant, 2'b01);
    check("t3_tie_addr", dma_rd_addr, IC_A1);

    // Both valid out of reset, releases via flush.
    do_reset();
    ic_v = 1'b1; ic_a = IC_A0; wf_v = 1'b1; wf_a = WF_A0;
    tick();
    dma_ack = 1'b1;
    mid();
    check("t4_ic_first", grant, 2'b01);
    tick();
    ic_v = 1'b0; dma_ack = 1'b0; flush = 1'b1;
    tick();
    flush = 1'b0; ic_v = 1'b1; ic_a = IC_A1;
    mid();
    check("t4_flush_idle_release", grant, 2'b00);
    tick();
    mid();
    check("t4_wf_second", grant, 2'b10);
    tick();
    dma_ack = 1'b1; flush = 1'b1;
    mid();
    check("t4_flush_ack_routed", {ic_rd_ack, wf_rd_ack}, 2'b01);
    tick();
    dma_ack = 1'b0; flush = 1'b0;
    mid();
    check("t4_flush_ack_release", grant, 2'b00);
    tick();
    mid();
    check("t4_ic_again", grant, 2'b01);

    // Flush with a WF beat outstanding goes through DRAIN.
    do_reset();
    wf_v = 1'b1; wf_a = WF_HI; flush = 1'b1;
    tick();
    flush = 1'b0;
    mid();
    check("t5_flush_in_arb_ignored", grant, 2'b10);
    check("t5_wide_addr", dma_rd_addr, WF_HI);
    tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    mid();
    check("t5_drain_busy", busy, 1'b1);
    check("t5_drain_grant", grant, 2'b10);
    check("t5_drain_valid", dma_rd_valid, 1'b1);
    tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    mid();
    check("t5_drain_held", {dma_rd_valid, grant}, 3'b110);
    tick();
    dma_ack = 1'b1; dma_data = DATA0;
    mid();
    check("t5_drain_ack", {ic_rd_ack, wf_rd_ack}, 2'b01);
    check("t5_drain_data", rd_data, DATA0);
    tick();
    wf_v = 1'b0; dma_ack = 1'b0;
    mid();
    check("t5_after_drain", {grant, busy, dma_rd_valid}, 4'b0000);

    // Reset at beat 100, then a full burst from beat 0.
    do_reset();
    ic_v = 1'b1; ic_a = IC_A0;
    tick();
    for (int b = 0; b < 100; b++) ic_beat(IC_A0);
    ic_v = 1'b1;
    mid();
    check("t6_pre_rst_grant", grant, 2'b01);
    rst = 1'b1;
    #1;
    check("t6_rst_same_cycle", {grant, busy, dma_rd_valid}, 4'b0000);
    tick();
    rst = 1'b0;
    mid();
    check("t6_rst_arb", grant, 2'b00);
    tick();
    ic_ack_cnt = 0; wf_ack_cnt = 0;
    for (int b = 0; b < 600; b++) begin
      ic_beat(IC_A0);
      if (z_grant == 2'b00) break;
    end
    check("t6_full_burst_after_rst", ic_ack_cnt, 512);
    check("t6_final_release", z_grant, 2'b00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
